// File: rtl/font_arb_pkg.sv
// Shared font ROM geometry and address packing for the font ROM arbiter.
package font_arb_pkg;

   localparam int FONT_CHAR_W = 7;
   localparam int FONT_ROW_W  = 4;
   localparam int FONT_DATA_W = 8;
   localparam int FONT_ADDR_W = FONT_CHAR_W + FONT_ROW_W;

   // Glyph rows of one character are contiguous in the ROM.
   function automatic logic [FONT_ADDR_W-1:0] font_addr(input logic [FONT_CHAR_W-1:0] ch,
                                                        input logic [FONT_ROW_W-1:0]  row);
      return {ch, row};
   endfunction

endpackage

// File: rtl/font_rom_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   int j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter with burst lock sharing one registered-output font ROM.
// FONT_ARB_RSP_REG_EN adds an output register stage (response latency 2 clk).
module font_rom_arbiter
   import font_arb_pkg::*;
#(
   parameter int  NUM_REQ = 2,
   parameter int  CHAR_W  = FONT_CHAR_W,
   parameter int  ROW_W   = FONT_ROW_W,
   parameter int  DATA_W  = FONT_DATA_W,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*CHAR_W-1:0] req_char,
   input  logic [NUM_REQ*ROW_W-1:0]  req_row,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [CHAR_W+ROW_W-1:0]   rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data
);

   // Handshake: a requester holds req/char/row until gnt; gnt[i] high means the
   // read is accepted at the next clk edge and its byte returns tagged with id i.
   logic              lock_valid_q, lock_valid_d;
   logic [ID_W-1:0]   lock_owner_q, lock_owner_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              tag_valid_q;
   logic [ID_W-1:0]   tag_id_q;

   logic [NUM_REQ-1:0] rr_gnt;
   logic [ID_W-1:0]    rr_idx, gnt_idx;
   logic               rr_any, gnt_any, lock_hold;
   logic [CHAR_W-1:0]  sel_char;
   logic [ROW_W-1:0]   sel_row;
   logic               rsp_valid_c;
   logic [ID_W-1:0]    rsp_id_c;
   logic [DATA_W-1:0]  rsp_data_c;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (rr_gnt),
      .idx_o (rr_idx),
      .any_o (rr_any)
   );

   // The owner keeps priority only while it still requests with lock asserted.
   assign lock_hold = lock_valid_q && req[lock_owner_q] && req_lock[lock_owner_q];

   always_comb begin
      gnt          = rr_gnt;
      gnt_idx      = rr_idx;
      gnt_any      = rr_any;
      sel_char     = '0;
      sel_row      = '0;
      lock_valid_d = 1'b0;
      lock_owner_d = lock_owner_q;
      rr_ptr_d     = rr_ptr_q;
      if (lock_hold) begin
         gnt               = '0;
         gnt[lock_owner_q] = 1'b1;
         gnt_idx           = lock_owner_q;
         gnt_any           = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_char = req_char[i*CHAR_W +: CHAR_W];
            sel_row  = req_row[i*ROW_W +: ROW_W];
         end
      end
      if (gnt_any) begin
         lock_valid_d = req_lock[gnt_idx];
         lock_owner_d = gnt_idx;
         rr_ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
   end

   assign rom_addr = {sel_char, sel_row};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_valid_q <= 1'b0;
         lock_owner_q <= '0;
         rr_ptr_q     <= '0;
         tag_valid_q  <= 1'b0;
         tag_id_q     <= '0;
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
         rr_ptr_q     <= rr_ptr_d;
         tag_valid_q  <= gnt_any;
         tag_id_q     <= gnt_idx;
      end
   end

   assign rsp_valid_c = tag_valid_q;
   assign rsp_id_c    = tag_id_q;
   assign rsp_data_c  = tag_valid_q ? rom_data : '0;

`ifdef FONT_ARB_RSP_REG_EN
   logic              rsp_valid_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [DATA_W-1:0] rsp_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_c;
         rsp_id_q    <= rsp_id_c;
         rsp_data_q  <= rsp_data_c;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
`else
   assign rsp_valid = rsp_valid_c;
   assign rsp_id    = rsp_id_c;
   assign rsp_data  = rsp_data_c;
`endif

endmodule
